muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative RV32M/RV64M multiply/divide execution unit that sits beside the single-cycle ALU in the execute stage. It decodes `funct3` of an M-extension instruction (`funct7 = 0000001`), computes the result over XLEN shift-add / restoring-divide iterations, and returns it through a start/busy/done handshake. Divide-by-zero and signed overflow bypass the iteration. The pipeline stalls on `busy`.

## Interface
- `XLEN`, default 32: operand and result width. Legal values are 8..64.
- `clk` input 1: clock. All state changes on the rising edge.
- `rst_n` input 1: reset. **Synchronous, active-low**, sampled on the rising edge of `clk`.
- `start` input 1: request. Sampled only when the unit is IDLE or DONE.
- `flush` input 1: synchronous abort of the operation in flight.
- `funct3` input 3: operation select, instr[14:12].
- `op_a` input XLEN: rs1 value (multiplicand / dividend).
- `op_b` input XLEN: rs2 value (multiplier / divisor).
- `busy` output 1: high while in CALC.
- `done` output 1: one-cycle pulse; `result` is valid in that cycle.
- `result` output XLEN: result. Held stable until the next accepted `start`.

## Operation
- `funct3` decode:
  - 000 MUL: low XLEN bits of the product.
  - 001 MULH: signed×signed, high half.
  - 010 MULHSU: signed a × unsigned b, high half.
  - 011 MULHU: unsigned×unsigned, high half.
  - 100 DIV: signed quotient.
  - 101 DIVU: unsigned quotient.
  - 110 REM: signed remainder.
  - 111 REMU: unsigned remainder.
- Operation, operand signedness, and operand/result sign flags are latched at accept. Inputs may change afterwards.
- **Multiply**
  - Operates on operand magnitudes with a 2*XLEN-bit accumulator, one multiplier bit per CALC cycle.
  - The final product is negated (two's complement, 2*XLEN wide) when the result sign is negative.
  - The low or high half is then selected per the decode above.
- **Divide**
  - Restoring divide on magnitudes, one quotient bit per CALC cycle.
  - Uses an XLEN+1-bit partial remainder.
  - Quotient is negated if the operand signs differ (signed ops only).
  - Remainder takes the sign of the dividend.
- **Special cases**, detected at accept; CALC is skipped:
  - Divisor = 0: DIV/DIVU give all-ones; REM/REMU give `op_a`.
  - Signed overflow (DIV/REM, `op_a` = 1 followed by zeros, `op_b` = all-ones): DIV gives `op_a`; REM gives 0.
- **FSM states:** IDLE, CALC, DONE.
  - IDLE or DONE, with `start`:
    - Special case: go to DONE.
    - Otherwise: go to CALC, with the iteration counter loaded to XLEN-1.
  - IDLE or DONE, without `start`: go to IDLE.
  - CALC, counter ≠ 0: decrement and stay in CALC.
  - CALC, counter = 0: go to DONE; sign fix-up and half select are applied on this edge.
  - `flush`: forces IDLE from any state.
    - No `done` is produced for the aborted operation.
    - `flush` has priority over `start` in the same cycle.
- `start` is ignored while in CALC.

## Timing
- **Reset:** while `rst_n` = 0 at a rising edge:
  - state becomes IDLE and the counter becomes 0.
  - `busy` = 0, `done` = 0, `result` = 0.
  - Reset mid-operation discards that operation.
- **Normal latency:** `start` is accepted at edge E0.
  - `busy` = 1 for the XLEN cycles following E0.
  - `done` = 1 in cycle XLEN+1 after E0 (cycle 33 for XLEN = 32).
  - `busy` = 0 in the DONE cycle.
- **Special-case latency:** `done` = 1 in the cycle immediately after E0; `busy` never rises.
- **Back-to-back:** a `start` sampled during the DONE cycle is accepted.
  - No idle bubble between operations.
  - `result` keeps the old value during that DONE cycle.
- `busy`, `done` and `result` are registered. There is no combinational path from inputs to outputs.
- **Flush:** asserted in any CALC cycle, `busy` = 0 from the next cycle; `result` keeps its previous value.

## Test plan
- Reset, then MUL `op_a` = 7, `op_b` = 0xFFFFFFFD (XLEN = 32) → `busy` high for cycles 1–32, `done` in cycle 33, `result` = 0xFFFFFFEB.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF × 2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF. DIVU 100 / 7 → 14. REMU 100 / 7 → 2.
- DIV by 0 → 0xFFFFFFFF. REM 0x1234 by 0 → 0x1234. DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM with the same operands → 0. For all of these: `done` in cycle 1, `busy` stays 0.
- Back-to-back: second `start` during the DONE cycle → second `done` exactly 33 cycles after the first. `start` pulsed in cycle 10 of CALC → ignored; result unchanged.
- Flush in cycle 10 of CALC → `busy` = 0 next cycle, no `done`, `result` unchanged. `rst_n` = 0 mid-CALC → all outputs 0 next cycle. A new op after either completes correctly.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M/RV64M multiply/divide unit for the execute stage.
// Multiplies by shift-add and divides by restoring division, one bit per cycle,
// on operand magnitudes; signs are fixed up on the final iteration edge.
// Divide-by-zero and signed overflow complete without iterating.
//
// Ports:
//   clk     - clock, all state changes on the rising edge
//   rst_n   - synchronous active-low reset
//   start   - operation request, honoured only in IDLE or DONE
//   flush   - synchronous abort, wins over start
//   funct3  - M-extension operation select (instr[14:12])
//   op_a    - rs1 (multiplicand / dividend)
//   op_b    - rs2 (multiplier / divisor)
//   busy    - high while iterating
//   done    - one-cycle pulse, result valid
//   result  - result, held until the next operation finishes
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Two's complement negate at operand width.
  function automatic logic [XLEN-1:0] neg_x(input logic [XLEN-1:0] v);
    return ~v + XLEN'(1);
  endfunction

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  // Multiply: {partial product high, multiplier shifting out}.
  // Divide: low half holds dividend bits shifting out / quotient shifting in.
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   dvs_q, dvs_d;      // multiplicand or divisor magnitude
  logic [XLEN-1:0]   rem_q, rem_d;      // partial remainder (always < divisor)
  logic              neg_q, neg_d;      // product / quotient is negative
  logic              neg_rem_q, neg_rem_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              a_sgn_s, b_sgn_s, a_neg_s, b_neg_s;
  logic [XLEN-1:0]   mag_a_s, mag_b_s, spec_res_s;
  logic              div_zero_s, ovf_s;
  logic [XLEN:0]     mul_sum_s, div_shift_s, div_diff_s;
  logic [2*XLEN-1:0] mul_acc_s, prod_s;
  logic              div_ge_s;
  logic [XLEN-1:0]   div_quo_s, div_rem_s, quo_s, rm_s;

  // Accept-time decode: signedness, magnitudes and special cases.
  always_comb begin
    case (funct3)
      3'b001, 3'b010, 3'b100, 3'b110: a_sgn_s = 1'b1;
      default:                        a_sgn_s = 1'b0;
    endcase
    case (funct3)
      3'b001, 3'b100, 3'b110: b_sgn_s = 1'b1;
      default:                b_sgn_s = 1'b0;
    endcase
    a_neg_s    = a_sgn_s & op_a[XLEN-1];
    b_neg_s    = b_sgn_s & op_b[XLEN-1];
    mag_a_s    = a_neg_s ? neg_x(op_a) : op_a;
    mag_b_s    = b_neg_s ? neg_x(op_b) : op_b;
    div_zero_s = funct3[2] & (op_b == {XLEN{1'b0}});
    ovf_s      = funct3[2] & ~funct3[0] & (op_a == MIN_NEG) & (op_b == {XLEN{1'b1}});
    if (div_zero_s) begin
      spec_res_s = funct3[1] ? op_a : {XLEN{1'b1}};
    end else begin
      spec_res_s = funct3[1] ? {XLEN{1'b0}} : op_a;
    end
  end

  // One iteration step of each datapath plus final sign fix-up.
  always_comb begin
    mul_sum_s   = {1'b0, acc_q[2*XLEN-1:XLEN]}
                + (acc_q[0] ? {1'b0, dvs_q} : {(XLEN+1){1'b0}});
    mul_acc_s   = {mul_sum_s, acc_q[XLEN-1:1]};
    div_shift_s = {rem_q, acc_q[XLEN-1]};
    div_diff_s  = div_shift_s - {1'b0, dvs_q};
    // No borrow out of the trial subtraction means divisor fits.
    div_ge_s    = ~div_diff_s[XLEN];
    div_rem_s   = div_ge_s ? div_diff_s[XLEN-1:0] : div_shift_s[XLEN-1:0];
    div_quo_s   = {acc_q[XLEN-2:0], div_ge_s};
    prod_s      = neg_q ? (~mul_acc_s + (2*XLEN)'(1)) : mul_acc_s;
    quo_s       = neg_q ? neg_x(div_quo_s) : div_quo_s;
    rm_s        = neg_rem_q ? neg_x(div_rem_s) : div_rem_s;
  end

  // Next-state, datapath load/step and registered output computation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    acc_d     = acc_q;
    dvs_d     = dvs_q;
    rem_d     = rem_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            op_d = funct3;
            if (div_zero_s || ovf_s) begin
              state_d  = S_DONE;
              result_d = spec_res_s;
            end else begin
              state_d   = S_CALC;
              cnt_d     = CW'(XLEN-1);
              rem_d     = {XLEN{1'b0}};
              neg_d     = a_neg_s ^ b_neg_s;
              neg_rem_d = a_neg_s;
              if (funct3[2]) begin
                acc_d = {{XLEN{1'b0}}, mag_a_s};
                dvs_d = mag_b_s;
              end else begin
                acc_d = {{XLEN{1'b0}}, mag_b_s};
                dvs_d = mag_a_s;
              end
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_CALC: begin
          if (op_q[2]) begin
            acc_d = {acc_q[2*XLEN-1:XLEN], div_quo_s};
            rem_d = div_rem_s;
          end else begin
            acc_d = mul_acc_s;
          end
          if (cnt_q != {CW{1'b0}}) begin
            cnt_d = cnt_q - CW'(1);
          end else begin
            state_d = S_DONE;
            case (op_q)
              3'b000:                 result_d = prod_s[XLEN-1:0];
              3'b001, 3'b010, 3'b011: result_d = prod_s[2*XLEN-1:XLEN];
              3'b100, 3'b101:         result_d = quo_s;
              3'b110, 3'b111:         result_d = rm_s;
              default:                result_d = {XLEN{1'b0}};
            endcase
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d == S_CALC);
    done_d = (state_d == S_DONE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= {CW{1'b0}};
      op_q      <= 3'b000;
      acc_q     <= {(2*XLEN){1'b0}};
      dvs_q     <= {XLEN{1'b0}};
      rem_q     <= {XLEN{1'b0}};
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= {XLEN{1'b0}};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      acc_q     <= acc_d;
      dvs_q     <= dvs_d;
      rem_q     <= rem_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed self-checking bench for muldiv_unit at XLEN = 32.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] op_a = 32'h0;
  logic [31:0] op_b = 32'h0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  // Issue one operation; must be called at a falling edge. start is driven in
  // the current cycle. Inputs are scrambled after accept. At cycle inj_cyc an
  // event is injected for one cycle: 1 = start pulse, 2 = flush, 3 = reset.
  // Outputs seen in cycle inj_cyc+1 are returned in *_nx.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input int inj_cyc, input int inj_kind,
                        output logic [31:0] res, output int done_cyc, output int busy_cnt,
                        output logic busy_nx, output logic done_nx, output logic [31:0] res_nx);
    funct3 = f; op_a = a; op_b = b; start = 1'b1;
    done_cyc = 0; busy_cnt = 0; res = 32'h0;
    busy_nx = 1'b0; done_nx = 1'b0; res_nx = 32'h0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0; flush = 1'b0; rst_n = 1'b1;
      funct3 = ~f; op_a = ~a; op_b = 32'h0;
      if (c == inj_cyc) begin
        case (inj_kind)
          1: begin start = 1'b1; funct3 = 3'b000; op_a = 32'd3; op_b = 32'd5; end
          2: flush = 1'b1;
          3: rst_n = 1'b0;
          default: ;
        endcase
      end
      if (c == inj_cyc + 1) begin
        busy_nx = busy; done_nx = done; res_nx = result;
      end
      if (busy) busy_cnt++;
      if (done && done_cyc == 0) begin
        done_cyc = c;
        res = result;
        if (inj_kind != 2 && inj_kind != 3) break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 00000000", result); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Normal (iterating) ops: result, done in cycle 33, busy for 32 cycles.
  task automatic test_arith();
    logic [2:0]  fv [0:9] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b100, 3'b110, 3'b101, 3'b111, 3'b000, 3'b100};
    logic [31:0] av [0:9] = '{32'd7, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9,
                              32'hFFFFFFF9, 32'd100, 32'd100, 32'h12345678, 32'd100};
    logic [31:0] bv [0:9] = '{32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'd2, 32'd2,
                              32'd2, 32'd7, 32'd7, 32'h10, 32'hFFFFFFF9};
    logic [31:0] ev [0:9] = '{32'hFFFFFFEB, 32'h40000000, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD,
                              32'hFFFFFFFF, 32'd14, 32'd2, 32'h23456780, 32'hFFFFFFF2};
    logic [31:0] r, rn; int dc, bc; logic bn, dn;
    for (int i = 0; i < 10; i++) begin
      run_op(fv[i], av[i], bv[i], 0, 0, r, dc, bc, bn, dn, rn);
      n_checks++; if (r !== ev[i]) begin n_fail++; $display("FAIL arith_result[%0d]: got %h expected %h", i, r, ev[i]); end
      n_checks++; if (dc !== 33) begin n_fail++; $display("FAIL arith_done_cycle[%0d]: got %0d expected 33", i, dc); end
      n_checks++; if (bc !== 32) begin n_fail++; $display("FAIL arith_busy_cycles[%0d]: got %0d expected 32", i, bc); end
      @(negedge clk);
    end
  endtask

  // Divide-by-zero and signed overflow: done in cycle 1, busy never high.
  task automatic test_special();
    logic [2:0]  fv [0:5] = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110};
    logic [31:0] av [0:5] = '{32'd55, 32'h1234, 32'd5, 32'd9, 32'h80000000, 32'h80000000};
    logic [31:0] bv [0:5] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] ev [0:5] = '{32'hFFFFFFFF, 32'h1234, 32'hFFFFFFFF, 32'd9, 32'h80000000, 32'h0};
    logic [31:0] r, rn; int dc, bc; logic bn, dn;
    for (int i = 0; i < 6; i++) begin
      run_op(fv[i], av[i], bv[i], 0, 0, r, dc, bc, bn, dn, rn);
      n_checks++; if (r !== ev[i]) begin n_fail++; $display("FAIL special_result[%0d]: got %h expected %h", i, r, ev[i]); end
      n_checks++; if (dc !== 1) begin n_fail++; $display("FAIL special_done_cycle[%0d]: got %0d expected 1", i, dc); end
      n_checks++; if (bc !== 0) begin n_fail++; $display("FAIL special_busy_cycles[%0d]: got %0d expected 0", i, bc); end
      @(negedge clk);
    end
  endtask

  // Second start in the DONE cycle of the first; old result holds meanwhile.
  task automatic test_back_to_back();
    logic [31:0] r1, r2, rn; int dc, bc; logic bn, dn;
    run_op(3'b101, 32'd100, 32'd7, 0, 0, r1, dc, bc, bn, dn, rn);
    run_op(3'b000, 32'd6, 32'd9, 10, 0, r2, dc, bc, bn, dn, rn);
    n_checks++; if (r1 !== 32'd14) begin n_fail++; $display("FAIL b2b_first: got %h expected 0000000e", r1); end
    n_checks++; if (dc !== 33) begin n_fail++; $display("FAIL b2b_spacing: got %0d expected 33", dc); end
    n_checks++; if (rn !== 32'd14) begin n_fail++; $display("FAIL b2b_hold: got %h expected 0000000e", rn); end
    n_checks++; if (r2 !== 32'd54) begin n_fail++; $display("FAIL b2b_second: got %h expected 00000036", r2); end
    @(negedge clk);
  endtask

  // start pulsed in cycle 10 of CALC is ignored.
  task automatic test_start_ignored();
    logic [31:0] r, rn; int dc, bc; logic bn, dn;
    run_op(3'b111, 32'd100, 32'd7, 10, 1, r, dc, bc, bn, dn, rn);
    n_checks++; if (r !== 32'd2) begin n_fail++; $display("FAIL ignstart_result: got %h expected 00000002", r); end
    n_checks++; if (dc !== 33) begin n_fail++; $display("FAIL ignstart_done_cycle: got %0d expected 33", dc); end
    n_checks++; if (bn !== 1'b1) begin n_fail++; $display("FAIL ignstart_busy: got %b expected 1", bn); end
    @(negedge clk);
  endtask

  // Flush in cycle 10: busy drops, no done, result keeps prior value (2).
  task automatic test_flush();
    logic [31:0] r, rn; int dc, bc; logic bn, dn;
    run_op(3'b000, 32'd7, 32'd8, 10, 2, r, dc, bc, bn, dn, rn);
    n_checks++; if (bn !== 1'b0) begin n_fail++; $display("FAIL flush_busy: got %b expected 0", bn); end
    n_checks++; if (dc !== 0) begin n_fail++; $display("FAIL flush_no_done: got done in cycle %0d expected none", dc); end
    n_checks++; if (rn !== 32'd2) begin n_fail++; $display("FAIL flush_result: got %h expected 00000002", rn); end
    n_checks++; if (bc !== 10) begin n_fail++; $display("FAIL flush_busy_cycles: got %0d expected 10", bc); end
    run_op(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, r, dc, bc, bn, dn, rn);
    n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL flush_after_op: got %h expected 00000000", r); end
    n_checks++; if (dc !== 33) begin n_fail++; $display("FAIL flush_after_cycle: got %0d expected 33", dc); end
    @(negedge clk);
  endtask

  // Reset in cycle 10 of CALC: all outputs zero next cycle, new op works.
  task automatic test_reset_mid();
    logic [31:0] r, rn; int dc, bc; logic bn, dn;
    run_op(3'b011, 32'hFFFFFFFF, 32'd3, 10, 3, r, dc, bc, bn, dn, rn);
    n_checks++; if (bn !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", bn); end
    n_checks++; if (dn !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b expected 0", dn); end
    n_checks++; if (rn !== 32'h0) begin n_fail++; $display("FAIL rstmid_result: got %h expected 00000000", rn); end
    n_checks++; if (dc !== 0) begin n_fail++; $display("FAIL rstmid_no_done: got done in cycle %0d expected none", dc); end
    run_op(3'b011, 32'hFFFFFFFF, 32'd3, 0, 0, r, dc, bc, bn, dn, rn);
    n_checks++; if (r !== 32'd2) begin n_fail++; $display("FAIL rstmid_after_op: got %h expected 00000002", r); end
    n_checks++; if (dc !== 33) begin n_fail++; $display("FAIL rstmid_after_cycle: got %0d expected 33", dc); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_arith();
    test_special();
    test_back_to_back();
    test_start_ignored();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
